// File: rtl/div_pkg.sv
// Shared types and helpers for the signed divider request/response front end.
// The negate/abs helpers work on a fixed 64-bit container. Callers zero-extend
// their operand, call the helper, then truncate back to their own width. Two's
// complement negation modulo 2^64, truncated to WIDTH bits, gives the same
// result as negation modulo 2^WIDTH, so this is exact for any WIDTH <= 64.
package div_pkg;

    // Width of the response status field.
    localparam int DIV_STATUS_W = 2;

    // Widest operand the helper functions below can handle.
    localparam int DIV_MAX_W = 64;

    // Controller states, in the order a normal request moves through them.
    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        FIX,
        RESP
    } div_ctrl_state_t;

    // Status codes reported alongside every response.
    typedef enum logic [DIV_STATUS_W-1:0] {
        DIV_OK      = 2'b00,
        DIV_DIV0    = 2'b01,
        DIV_OVF     = 2'b10,
        DIV_TIMEOUT = 2'b11
    } div_status_t;

    // Two's complement negation.
    function automatic logic [DIV_MAX_W-1:0] div_negate(
        input logic [DIV_MAX_W-1:0] value
    );
        return -value;
    endfunction

    // Negate only when asked. This is used both for sign correction and for
    // taking magnitudes.
    function automatic logic [DIV_MAX_W-1:0] div_cond_negate(
        input logic [DIV_MAX_W-1:0] value,
        input logic                 negate
    );
        return negate ? div_negate(value) : value;
    endfunction

    // Absolute value of a two's complement number whose sign bit is given
    // separately. The caller extracts the sign bit at its own width.
    // Note that abs(MIN) comes back as MIN. Read as an unsigned number, that
    // is the correct magnitude.
    function automatic logic [DIV_MAX_W-1:0] div_abs(
        input logic [DIV_MAX_W-1:0] value,
        input logic                 signBit
    );
        return div_cond_negate(value, signBit);
    endfunction

endpackage

// File: rtl/div_signed_ctrl.sv
// Request-side front end for the sequential unsigned divider core.
// It accepts signed or unsigned divide requests. Divide-by-zero and the single
// signed overflow case (MIN / -1) are answered locally without the core.
// Every other request is reduced to magnitudes and handed to the core. The
// core's unsigned result is then sign-corrected before the response goes out.
// The core itself lives beside this block in the parent.
module div_signed_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_signed_i,
    input  logic [WIDTH-1:0] req_dividend_i,
    input  logic [WIDTH-1:0] req_divisor_i,

    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [WIDTH-1:0] resp_quotient_o,
    output logic [WIDTH-1:0] resp_remainder_o,
    output logic [DIV_STATUS_W-1:0] resp_status_o,

    output logic             core_start_o,
    output logic [WIDTH-1:0] core_dividend_o,
    output logic [WIDTH-1:0] core_divisor_o,
    input  logic             core_done_i,
    input  logic [WIDTH-1:0] core_quotient_i,
    input  logic [WIDTH-1:0] core_remainder_i
);

    // The wait timer counts 0..TIMEOUT-1 and only needs to hold TIMEOUT.
    localparam int TIMER_W = $clog2(TIMEOUT + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);

    // Most negative two's complement value, and -1.
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    div_ctrl_state_t      state_q;
    logic [TIMER_W-1:0]   timer_q;
    logic                 negQuot_q;
    logic                 negRem_q;
    logic                 resp_valid_q;
    logic [WIDTH-1:0]     resp_quotient_q;
    logic [WIDTH-1:0]     resp_remainder_q;
    div_status_t          resp_status_q;
    logic                 core_start_q;
    logic [WIDTH-1:0]     core_dividend_q;
    logic [WIDTH-1:0]     core_divisor_q;

    // Classification and magnitudes of the request currently on the inputs.
    logic                 isDiv0;
    logic                 isOvf;
    logic                 dividendNeg;
    logic                 divisorNeg;
    logic [WIDTH-1:0]     magDividend;
    logic [WIDTH-1:0]     magDivisor;

    // Sign-corrected versions of the captured core result, used in FIX.
    logic [WIDTH-1:0]     fixedQuotient;
    logic [WIDTH-1:0]     fixedRemainder;

    // Requests are taken only in IDLE. The ready is also forced low while reset
    // is held, so nothing can slip in during the reset itself.
    assign req_ready_o = (state_q == IDLE) && !reset;

    // Classify the incoming request and form the magnitudes that go to the core.
    // Operand signs only count for signed requests. An unsigned request sends
    // its raw bits through unchanged.
    always_comb begin
        dividendNeg = req_signed_i && req_dividend_i[WIDTH-1];
        divisorNeg  = req_signed_i && req_divisor_i[WIDTH-1];
        isDiv0      = (req_divisor_i == '0);
        isOvf       = req_signed_i && (req_dividend_i == MIN_VAL) &&
                      (req_divisor_i == ALL_ONES);
        magDividend = WIDTH'(div_abs(DIV_MAX_W'(req_dividend_i), dividendNeg));
        magDivisor  = WIDTH'(div_abs(DIV_MAX_W'(req_divisor_i), divisorNeg));
    end

    // Apply the recorded sign decisions to the unsigned result captured from the core.
    always_comb begin
        fixedQuotient  = WIDTH'(div_cond_negate(DIV_MAX_W'(resp_quotient_q), negQuot_q));
        fixedRemainder = WIDTH'(div_cond_negate(DIV_MAX_W'(resp_remainder_q), negRem_q));
    end

    // Main controller. It handles request intake, core issue, the bounded wait
    // for the core, sign correction, and response hold until the consumer takes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            timer_q          <= '0;
            negQuot_q        <= 1'b0;
            negRem_q         <= 1'b0;
            resp_valid_q     <= 1'b0;
            resp_quotient_q  <= '0;
            resp_remainder_q <= '0;
            resp_status_q    <= DIV_OK;
            core_start_q     <= 1'b0;
            core_dividend_q  <= '0;
            core_divisor_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        if (isDiv0) begin
                            resp_quotient_q  <= ALL_ONES;
                            resp_remainder_q <= req_dividend_i;
                            resp_status_q    <= DIV_DIV0;
                            resp_valid_q     <= 1'b1;
                            state_q          <= RESP;
                        end else if (isOvf) begin
                            resp_quotient_q  <= MIN_VAL;
                            resp_remainder_q <= '0;
                            resp_status_q    <= DIV_OVF;
                            resp_valid_q     <= 1'b1;
                            state_q          <= RESP;
                        end else begin
                            core_dividend_q  <= magDividend;
                            core_divisor_q   <= magDivisor;
                            negQuot_q        <= dividendNeg ^ divisorNeg;
                            negRem_q         <= dividendNeg;
                            core_start_q     <= 1'b1;
                            state_q          <= ISSUE;
                        end
                    end
                end

                ISSUE: begin
                    core_start_q <= 1'b0;
                    timer_q      <= '0;
                    state_q      <= WAIT;
                end

                WAIT: begin
                    if (core_done_i) begin
                        resp_quotient_q  <= core_quotient_i;
                        resp_remainder_q <= core_remainder_i;
                        state_q          <= FIX;
                    end else if (timer_q == TIMER_LAST) begin
                        resp_quotient_q  <= '0;
                        resp_remainder_q <= '0;
                        resp_status_q    <= DIV_TIMEOUT;
                        resp_valid_q     <= 1'b1;
                        state_q          <= RESP;
                    end else begin
                        timer_q <= timer_q + TIMER_ONE;
                    end
                end

                FIX: begin
                    resp_quotient_q  <= fixedQuotient;
                    resp_remainder_q <= fixedRemainder;
                    resp_status_q    <= DIV_OK;
                    resp_valid_q     <= 1'b1;
                    state_q          <= RESP;
                end

                RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign resp_valid_o     = resp_valid_q;
    assign resp_quotient_o  = resp_quotient_q;
    assign resp_remainder_o = resp_remainder_q;
    assign resp_status_o    = resp_status_q;
    assign core_start_o     = core_start_q;
    assign core_dividend_o  = core_dividend_q;
    assign core_divisor_o   = core_divisor_q;

endmodule
